// File: rtl/q_reserve_fifo.sv
// Skid-tolerant FIFO with a registered back-pressure threshold and free-slot reserve.
// Ports: clock, reset (async, low), i_d/i_v/i_b in, o_d/o_v/o_b out; ovf when Q_RESERVE_FIFO_OVF_EN.
module q_reserve_fifo #(
  parameter int depth   = 16,
  parameter int width   = 16,
  parameter int reserve = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] i_d,
  input  logic             i_v,
  output logic             i_b,
  output logic [width-1:0] o_d,
  output logic             o_v,
  input  logic             o_b
`ifdef Q_RESERVE_FIFO_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PW-1:0] LAST = PW'(depth - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [8:0] FULL = 9'(depth);
  localparam logic [8:0] THR  = 9'(depth - reserve);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [8:0]       count;
  logic [8:0]       count_nx;
  logic             enq;
  logic             deq;

  // Count is already 0 in reset; gating keeps o_v low regardless of o_b.
  assign o_v = reset && (count != 9'd0) && !o_b;
  assign deq = o_v;
  // At full, a same-cycle dequeue frees the slot the write lands in.
  assign enq = i_v && ((count != FULL) || deq);
  assign o_d = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    if (enq && !deq)
      count_nx = count + 9'd1;
    else if (deq && !enq)
      count_nx = count - 9'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= 9'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      i_b    <= 1'b1;
    end else begin
      count <= count_nx;
      i_b   <= (count_nx >= THR);
      if (enq)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ONE;
      if (deq)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (enq)
      mem[wr_ptr] <= i_d;
  end

`ifdef Q_RESERVE_FIFO_OVF_EN
  // Sticky until reset: any item dropped at full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ovf <= 1'b0;
    else if (i_v && !enq)
      ovf <= 1'b1;
  end
`endif

endmodule
